// File: rtl/ctrl_pipe.sv
// Pipelined control-signal carrier: ID/EX, EX/MEM, MEM/WB stage registers with bubble/squash.
// Optional bubble statistics counter is compiled in with `define CTRL_PIPE_STATS_EN.
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  ex_in,
  input  logic [2:0]  m_in,
  input  logic [1:0]  wb_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        alu_zero,
  output logic        reg_dst,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        pc_src
`ifdef CTRL_PIPE_STATS_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  localparam int STAGES = 3;

  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
  } idex_t;

  typedef struct packed {
    logic [2:0] m;
    logic [1:0] wb;
    logic       zero;
  } exmem_t;

  typedef struct packed {
    logic [1:0] wb;
  } memwb_t;

  // r_vld_pipe[0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB
  logic [STAGES-1:0] r_vld_pipe;
  idex_t             r_idex;
  exmem_t            r_exmem;
  memwb_t            r_memwb;

  logic              w_bubble;
  logic [3:0]        w_ex;
  logic [2:0]        w_m;
  logic [1:0]        w_wb;

  assign w_bubble = stall | flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_idex     <= '0;
      r_exmem    <= '0;
      r_memwb    <= '0;
    end else begin
      // Invalid bundles are stored as zeros so don't-care inputs never linger.
      if (w_bubble) begin
        r_vld_pipe[0] <= 1'b0;
        r_idex        <= '0;
      end else begin
        r_vld_pipe[0] <= in_valid;
        r_idex.ex     <= in_valid ? ex_in : 4'b0;
        r_idex.m      <= in_valid ? m_in  : 3'b0;
        r_idex.wb     <= in_valid ? wb_in : 2'b0;
      end

      if (flush) begin
        r_vld_pipe[1] <= 1'b0;
        r_exmem       <= '0;
      end else begin
        r_vld_pipe[1] <= r_vld_pipe[0];
        r_exmem.m     <= r_idex.m;
        r_exmem.wb    <= r_idex.wb;
        r_exmem.zero  <= alu_zero;
      end

      r_vld_pipe[2] <= r_vld_pipe[1];
      r_memwb.wb    <= r_exmem.wb;
    end
  end

  assign w_ex = r_idex.ex  & {4{r_vld_pipe[0]}};
  assign w_m  = r_exmem.m  & {3{r_vld_pipe[1]}};
  assign w_wb = r_memwb.wb & {2{r_vld_pipe[2]}};

  assign reg_dst    = w_ex[3];
  assign alu_op     = w_ex[2:1];
  assign alu_src    = w_ex[0];
  assign branch     = w_m[2];
  assign mem_read   = w_m[1];
  assign mem_write  = w_m[0];
  assign reg_write  = w_wb[1];
  assign mem_to_reg = w_wb[0];
  assign pc_src     = r_vld_pipe[1] & r_exmem.m[2] & r_exmem.zero;

`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_bubble_cnt <= '0;
    else if (w_bubble && (r_bubble_cnt != 16'hFFFF))
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Table-driven bench for ctrl_pipe: vectors carry hand-derived stage outputs, routed through a scoreboard queue.
module tb_ctrl_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  ex_in;
  logic [2:0]  m_in;
  logic [1:0]  wb_in;
  logic        stall;
  logic        flush;
  logic        alu_zero;
  logic        reg_dst;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        branch;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        pc_src;
`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] bubble_cnt;
`endif

  ctrl_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ex_in     (ex_in),
    .m_in      (m_in),
    .wb_in     (wb_in),
    .stall     (stall),
    .flush     (flush),
    .alu_zero  (alu_zero),
    .reg_dst   (reg_dst),
    .alu_op    (alu_op),
    .alu_src   (alu_src),
    .branch    (branch),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .mem_to_reg(mem_to_reg),
    .pc_src    (pc_src)
`ifdef CTRL_PIPE_STATS_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic       st;
    logic       fl;
    logic       z;
    logic [3:0] eex;
    logic [2:0] em;
    logic [1:0] ewb;
    logic       epc;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  int          n_chk;
  int          n_err;
  logic [15:0] exp_cnt;

  task automatic add(input logic r, input logic iv, input logic [3:0] ex, input logic [2:0] m,
                     input logic [1:0] wb, input logic st, input logic fl, input logic z,
                     input logic [3:0] eex, input logic [2:0] em, input logic [1:0] ewb,
                     input logic epc);
    vec_t v;
    v.rst = r;  v.iv = iv; v.ex = ex; v.m = m; v.wb = wb;
    v.st = st;  v.fl = fl; v.z = z;
    v.eex = eex; v.em = em; v.ewb = ewb; v.epc = epc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, track the expected bubble count, sample after the edge.
  task automatic drive_edge(input vec_t v);
    rst = v.rst; in_valid = v.iv; ex_in = v.ex; m_in = v.m; wb_in = v.wb;
    stall = v.st; flush = v.fl; alu_zero = v.z;
    if (v.rst)
      exp_cnt = 16'd0;
    else if ((v.st || v.fl) && exp_cnt != 16'hFFFF)
      exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int idx, input logic [3:0] eex, input logic [2:0] em,
                            input logic [1:0] ewb, input logic epc);
    chk("ex_ctrl",  idx, {12'd0, reg_dst, alu_op, alu_src}, {12'd0, eex});
    chk("mem_ctrl", idx, {13'd0, branch, mem_read, mem_write}, {13'd0, em});
    chk("wb_ctrl",  idx, {14'd0, reg_write, mem_to_reg}, {14'd0, ewb});
    chk("pc_src",   idx, {15'd0, pc_src}, {15'd0, epc});
`ifdef CTRL_PIPE_STATS_EN
    chk("bubble_cnt", idx, bubble_cnt, exp_cnt);
`endif
  endtask

  initial begin
    vec_t v;
    vec_t e;
    n_chk = 0; n_err = 0; exp_cnt = 16'd0;
    rst = 1'b0; in_valid = 1'b0; ex_in = '0; m_in = '0; wb_in = '0;
    stall = 1'b0; flush = 1'b0; alu_zero = 1'b0;

    //   rst iv  ex       m       wb     st fl z   | ex       m       wb     pc
    // RTYPE through an empty pipe
    add(1, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 1, 4'b1100, 3'b000, 2'b10, 0, 0, 0,   4'b1100, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b10, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    // LW, then dependent RTYPE stalled one cycle and re-presented
    add(0, 1, 4'b0001, 3'b010, 2'b11, 0, 0, 0,   4'b0001, 3'b000, 2'b00, 0);
    add(0, 1, 4'b1100, 3'b000, 2'b10, 1, 0, 0,   4'b0000, 3'b010, 2'b00, 0);
    add(0, 1, 4'b1100, 3'b000, 2'b10, 0, 0, 0,   4'b1100, 3'b000, 2'b11, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b10, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    // BEQ taken: zero sampled while BEQ is in EX
    add(0, 1, 4'b1010, 3'b100, 2'b01, 0, 0, 0,   4'b1010, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 1,   4'b0000, 3'b100, 2'b00, 1);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 1,   4'b0000, 3'b000, 2'b01, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    // BEQ not taken
    add(0, 1, 4'b1010, 3'b100, 2'b01, 0, 0, 0,   4'b1010, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b100, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b01, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    // Back-to-back LW, RTYPE, SW, then flush+stall together
    add(0, 1, 4'b0001, 3'b010, 2'b11, 0, 0, 0,   4'b0001, 3'b000, 2'b00, 0);
    add(0, 1, 4'b1100, 3'b000, 2'b10, 0, 0, 0,   4'b1100, 3'b010, 2'b00, 0);
    add(0, 1, 4'b0001, 3'b001, 2'b00, 0, 0, 0,   4'b0001, 3'b000, 2'b11, 0);
    add(0, 1, 4'b1100, 3'b000, 2'b10, 1, 1, 0,   4'b0000, 3'b000, 2'b10, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    // Flush alone squashes a branch in EX even with zero=1
    add(0, 1, 4'b0110, 3'b100, 2'b00, 0, 0, 0,   4'b0110, 3'b000, 2'b00, 0);
    add(0, 1, 4'b1100, 3'b000, 2'b10, 0, 1, 1,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    // Invalid bundle with junk fields never shows up
    add(0, 0, 4'b1111, 3'b111, 2'b11, 0, 0, 1,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 1,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    // Reset with three bundles in flight; rst overrides stall
    add(0, 1, 4'b0001, 3'b010, 2'b11, 0, 0, 0,   4'b0001, 3'b000, 2'b00, 0);
    add(0, 1, 4'b1100, 3'b000, 2'b10, 0, 0, 0,   4'b1100, 3'b010, 2'b00, 0);
    add(0, 1, 4'b1010, 3'b100, 2'b01, 0, 0, 1,   4'b1010, 3'b000, 2'b11, 0);
    add(1, 1, 4'b0001, 3'b010, 2'b11, 1, 0, 1,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 1,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);
    add(0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,   4'b0000, 3'b000, 2'b00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      sb.push_back(v);
      drive_edge(v);
      e = sb.pop_front();
      check_outs(i, e.eex, e.em, e.ewb, e.epc);
    end

    // Reset held with stall and flush asserted: nothing counts, nothing enters
    v.rst = 1; v.iv = 1; v.ex = 4'b1111; v.m = 3'b111; v.wb = 2'b11;
    v.st = 1; v.fl = 1; v.z = 1;
    drive_edge(v);
    drive_edge(v);
    check_outs(100, 4'b0000, 3'b000, 2'b00, 1'b0);

    // Stall alone bubbles a valid bundle and counts once
    v.rst = 0; v.fl = 0;
    drive_edge(v);
    check_outs(101, 4'b0000, 3'b000, 2'b00, 1'b0);

    // All-ones bundle flows through unmodified, branch taken
    v.st = 0;
    drive_edge(v);
    check_outs(102, 4'b1111, 3'b000, 2'b00, 1'b0);
    v.iv = 0; v.z = 1;
    drive_edge(v);
    check_outs(103, 4'b0000, 3'b111, 2'b00, 1'b1);
    v.z = 0;
    drive_edge(v);
    check_outs(104, 4'b0000, 3'b000, 2'b11, 1'b0);
    drive_edge(v);
    check_outs(105, 4'b0000, 3'b000, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  decode stage presents a valid control bundle this cycle.
REQ-004 SHALL have port ex_in  input  4  decoder EX bundle {reg_dst, alu_op[1:0], alu_src}.
REQ-005 SHALL have port m_in  input  3  decoder M bundle {branch, mem_read, mem_write}.
REQ-006 SHALL have port wb_in  input  2  decoder WB bundle {reg_write, mem_to_reg}.
REQ-007 SHALL have port stall  input  1  load-use hazard; insert bubble into ID/EX this cycle.
REQ-008 SHALL have port flush  input  1  branch redirect; squash ID/EX and EX/MEM this cycle.
REQ-009 SHALL have port alu_zero  input  1  ALU zero flag from the instruction currently in EX.
REQ-010 SHALL have outputs reg_dst (1), alu_op (2), alu_src (1)  output  EX-stage controls from ID/EX register.
REQ-011 SHALL have outputs branch (1), mem_read (1), mem_write (1)  output  MEM-stage controls from EX/MEM register.
REQ-012 SHALL have outputs reg_write (1), mem_to_reg (1)  output  WB-stage controls from MEM/WB register.
REQ-013 SHALL have output pc_src  output  1  branch taken, resolved in MEM.
REQ-014 SHALL have output bubble_cnt  output  16  bubbles inserted (present only with CTRL_PIPE_STATS_EN).

Function
REQ-015 SHALL hold three stage registers ID/EX {v, ex, m, wb}, EX/MEM {v, m, wb, zero}, MEM/WB {v, wb}, each with a valid bit.
REQ-016 SHALL advance all stages every cycle; no stage holds its value (stall creates a bubble, it does not freeze).
REQ-017 SHALL capture ID/EX <= {in_valid, ex_in, m_in, wb_in} when stall=0 and flush=0.
REQ-018 SHALL capture EX/MEM <= {ID/EX.v, ID/EX.m, ID/EX.wb, alu_zero} when flush=0.
REQ-019 SHALL capture MEM/WB <= {EX/MEM.v, EX/MEM.wb} unconditionally.
REQ-020 SHALL load a bubble (v=0, all fields 0) into ID/EX when stall=1 or flush=1.
REQ-021 SHALL load a bubble into EX/MEM when flush=1. MEM/WB is never squashed.
REQ-022 SHALL give flush priority over stall when both are asserted. Result: ID/EX and EX/MEM are both bubbles.
REQ-023 SHALL drive each stage output combinationally from its register, gated by that stage's valid bit. An invalid stage drives all zeros.
REQ-024 SHALL give a bundle accepted at edge N a latency as follows: EX outputs visible after edge N, MEM outputs after N+1, WB outputs after N+2.
REQ-025 SHALL compute pc_src = EX/MEM.v & EX/MEM.branch & EX/MEM.zero.
REQ-026 SHALL store X/don't-care input bits as 0 when in_valid=0.
REQ-027 SHALL store bits of a valid bundle unmodified.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear all three valid bits and all stored fields to 0. rst overrides stall and flush.
REQ-029 SHALL drive all outputs, including pc_src, to 0 in the cycle after reset. In-flight bundles are discarded when reset arrives mid-operation.
REQ-030 SHALL clear bubble_cnt to 0 on reset (when CTRL_PIPE_STATS_EN is defined).

Configuration
REQ-031 SHALL compile a bubble statistics counter only when CTRL_PIPE_STATS_EN is defined.
REQ-032 SHALL, with CTRL_PIPE_STATS_EN defined, increment bubble_cnt by 1 on each edge where stall=1 or flush=1 (not on rst), saturating at 16'hFFFF.
REQ-033 SHALL, without CTRL_PIPE_STATS_EN, omit the bubble_cnt port and counter, with all other behaviour identical.

Verification
REQ-034 SHALL cover this case: reset, then one valid RTYPE bundle (ex=1100, m=000, wb=10). Required: reg_dst=1, alu_op=10 after 1 edge; reg_write=1, mem_to_reg=0 after 3 edges; zeros otherwise.
REQ-035 SHALL cover this case: LW (0001/010/11) then stall=1 for one cycle. Required: mem_read=1 at MEM after edge 2; ID/EX is a bubble on the stalled cycle; bubble_cnt=1.
REQ-036 SHALL cover this case: BEQ (x010/100/0x) with alu_zero=1 in EX. Required: pc_src=1 for exactly one cycle after edge 2.
REQ-037 SHALL cover this case: BEQ with alu_zero=0. Required: pc_src stays 0.
REQ-038 SHALL cover this case: back-to-back valid bundles with flush=1 and stall=1 on the same edge. Required: ID/EX and EX/MEM both zero, the MEM/WB bundle still retires, and bubble_cnt increments by 1.
REQ-039 SHALL cover this case: rst=1 asserted while three valid bundles are in flight. Required: all outputs 0 on the next cycle, and nothing retires afterwards.
